// File: rtl/whack_pkg.sv
// ---------------------------------------------------------------------------
// whack_pkg
//
// Purpose:
//    Shared definitions for the whack-a-mole game datapath: the hit
//    classifier state encoding, the system clock rate and the largest
//    supported mole count. Also provides a helper that sizes the lockout
//    down-counter so every user of the package derives it the same way.
//
// Contents:
//    hc_state_t            hit classifier FSM states (IDLE, ARMED, LOCKOUT)
//    CLK_HZ                system clock frequency in Hz
//    MAX_MOLES             upper bound on the number of mole holes
//    lockout_cnt_width()   bits needed to hold a lockout count
// ---------------------------------------------------------------------------
package whack_pkg;

   // System clock of the board; lockout lengths are expressed in these cycles.
   localparam int CLK_HZ = 50_000_000;

   // Widest button/mole vector any block in the game has to cope with.
   localparam int MAX_MOLES = 18;

   // Hit classifier states. IDLE swallows everything until a round starts,
   // ARMED classifies presses, LOCKOUT ignores presses after a miss.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      LOCKOUT = 2'd2
   } hc_state_t;

   // The counter has to hold LOCKOUT_CYCLES-1 as its load value, so
   // $clog2(cycles+1) bits are plenty. A disabled lockout (0 cycles) still
   // needs a one-bit register so the declaration stays legal.
   function automatic int lockout_cnt_width(input int cycles);
      if (cycles < 1) begin
         return 1;
      end
      return ($clog2(cycles + 1) < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
//
// Purpose:
//    Registers a vector of already-synchronised levels and reports which bits
//    went from 0 to 1 since the previous clock. The history register updates
//    every cycle unconditionally, so a level held across any change in the
//    consumer's state never shows up later as a stale rising edge.
//
// Ports:
//    clk     in   system clock
//    reset   in   synchronous active-low reset, clears the history register
//    level   in   [WIDTH] current levels (1 = asserted)
//    rise    out  [WIDTH] level & ~previous level, combinational
// ---------------------------------------------------------------------------
module rise_detect #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] level_q;

   // Remember last cycle's levels. Clearing to zero on reset means a button
   // already held when reset releases looks like a fresh edge for one cycle;
   // the consumer decides whether that cycle is allowed to act on it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         level_q <= '0;
      end else begin
         level_q <= level;
      end
   end

   // A bit rises when it is high now and was low on the previous edge.
   assign rise = level & ~level_q;

endmodule

// File: rtl/hit_classifier.sv
// ---------------------------------------------------------------------------
// hit_classifier
//
// Purpose:
//    Sits in front of the combo counter. Turns debounced button levels and
//    the mole controller's "mole up" mask into single-cycle scoring events,
//    knocks struck moles down through mole_whack, and imposes a lockout after
//    every miss so mashing buttons cannot farm hits.
//
// Ports:
//    clk                 in   system clock (50 MHz)
//    reset               in   synchronous active-low reset
//    game_active         in   high while a round runs; low forces IDLE
//    btn                 in   [N_MOLES] debounced button levels, 1 = pressed
//    mole_up             in   [N_MOLES] moles currently visible
//    miss                out  one-cycle pulse for a wrong press
//    non_full_clear_hit  out  one-cycle pulse, valid hit with moles left up
//    full_clear_hit      out  one-cycle pulse, valid hit clearing the board
//    mole_whack          out  [N_MOLES] one-cycle pulse per struck mole
//    locked_out          out  high while presses are being ignored
//
// All outputs are registered; an event appears in the cycle after the edge
// that first samples the press.
// ---------------------------------------------------------------------------
module hit_classifier
   import whack_pkg::*;
#(
   parameter int N_MOLES        = 8,
   parameter int LOCKOUT_CYCLES = 25_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               game_active,
   input  logic [N_MOLES-1:0] btn,
   input  logic [N_MOLES-1:0] mole_up,
   output logic               miss,
   output logic               non_full_clear_hit,
   output logic               full_clear_hit,
   output logic [N_MOLES-1:0] mole_whack,
   output logic               locked_out
);

   // Counter sizing and the value loaded on a miss. The counter runs from
   // LOCKOUT_CYCLES-1 down to 0 inclusive, which is exactly LOCKOUT_CYCLES
   // cycles spent in LOCKOUT.
   localparam int           CNT_W       = lockout_cnt_width(LOCKOUT_CYCLES);
   localparam int           LOAD_VAL    = (LOCKOUT_CYCLES > 0) ? (LOCKOUT_CYCLES - 1) : 0;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);
   localparam bit           LOCKOUT_EN  = (LOCKOUT_CYCLES > 0);

   hc_state_t          state;
   logic [CNT_W-1:0]   cnt;
   logic [N_MOLES-1:0] knocked;
   logic [N_MOLES-1:0] rise;
   logic [N_MOLES-1:0] live;
   logic [N_MOLES-1:0] wrong;
   logic [N_MOLES-1:0] hits;

   // Edge detection on the raw button levels. The history register keeps
   // tracking in every state, so a button held through IDLE or LOCKOUT is
   // already "old" by the time presses are being classified again.
   rise_detect #(
      .WIDTH (N_MOLES)
   ) u_rise_detect (
      .clk   (clk),
      .reset (reset),
      .level (btn),
      .rise  (rise)
   );

   // A mole is only worth hitting while it is up and has not already been
   // whacked in its current appearance. Any new press on a mole that is not
   // live is a wrong press; the rest are valid hits.
   always_comb begin
      live  = mole_up & ~knocked;
      wrong = rise & ~live;
      hits  = rise & live;
   end

   // Main FSM with registered event outputs. Event pulses default low every
   // cycle so each one lasts exactly a single cycle. The knocked mask drops a
   // bit as soon as that mole goes down, and gains bits on the same edge the
   // matching mole_whack pulse is launched, so a second press on a struck
   // mole is judged as a miss even before the mole controller reacts.
   // A miss wins over any valid hits pressed on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= IDLE;
         cnt                <= '0;
         knocked            <= '0;
         miss               <= 1'b0;
         non_full_clear_hit <= 1'b0;
         full_clear_hit     <= 1'b0;
         mole_whack         <= '0;
         locked_out         <= 1'b0;
      end else begin
         miss               <= 1'b0;
         non_full_clear_hit <= 1'b0;
         full_clear_hit     <= 1'b0;
         mole_whack         <= '0;
         knocked            <= knocked & mole_up;

         if (!game_active) begin
            state      <= IDLE;
            cnt        <= '0;
            locked_out <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state      <= ARMED;
                  locked_out <= 1'b0;
               end

               ARMED: begin
                  if (wrong != '0) begin
                     miss <= 1'b1;
                     if (LOCKOUT_EN) begin
                        state      <= LOCKOUT;
                        cnt        <= CNT_LOAD;
                        locked_out <= 1'b1;
                     end
                  end else if (hits != '0) begin
                     mole_whack <= hits;
                     knocked    <= (knocked | hits) & mole_up;
                     if ((live & ~hits) == '0) begin
                        full_clear_hit <= 1'b1;
                     end else begin
                        non_full_clear_hit <= 1'b1;
                     end
                  end
               end

               LOCKOUT: begin
                  if (cnt == '0) begin
                     state      <= ARMED;
                     locked_out <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end

               default: begin
                  state      <= IDLE;
                  cnt        <= '0;
                  locked_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hit_classifier.sv
// ---------------------------------------------------------------------------
// tb_hit_classifier
//
// Purpose:
//    Directed test of hit_classifier with N_MOLES=8 and a short lockout of
//    10 cycles. Inputs change 1 ns after a rising edge; outputs are read
//    1 ns after the following rising edge, so each press is observed in the
//    cycle its event pulse is expected.
// ---------------------------------------------------------------------------
module tb_hit_classifier;
   import whack_pkg::*;

   localparam int N_MOLES        = 8;
   localparam int LOCKOUT_CYCLES = 10;

   logic               clk;
   logic               reset;
   logic               game_active;
   logic [N_MOLES-1:0] btn;
   logic [N_MOLES-1:0] mole_up;
   logic               miss;
   logic               non_full_clear_hit;
   logic               full_clear_hit;
   logic [N_MOLES-1:0] mole_whack;
   logic               locked_out;

   int totalChecks;
   int badChecks;
   int lockCount;
   int eventCount;
   int hitCount;

   hit_classifier #(
      .N_MOLES        (N_MOLES),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .game_active        (game_active),
      .btn                (btn),
      .mole_up            (mole_up),
      .miss               (miss),
      .non_full_clear_hit (non_full_clear_hit),
      .full_clear_hit     (full_clear_hit),
      .mole_whack         (mole_whack),
      .locked_out         (locked_out)
   );

   // 100 MHz simulation clock; the period is irrelevant to the logic.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      totalChecks++;
      if (got !== want) begin
         badChecks++;
         $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Checks all three event flags and the whack vector in one go.
   task automatic checkEvents(input string tag, input logic expMiss, input logic expNfc,
                              input logic expFc, input logic [N_MOLES-1:0] expWhack);
      checkOutput({tag, "_miss"}, 32'(miss), 32'(expMiss));
      checkOutput({tag, "_nfc"}, 32'(non_full_clear_hit), 32'(expNfc));
      checkOutput({tag, "_fc"}, 32'(full_clear_hit), 32'(expFc));
      checkOutput({tag, "_whack"}, 32'(mole_whack), 32'(expWhack));
   endtask

   initial begin
      totalChecks = 0;
      badChecks   = 0;
      reset       = 1'b0;
      game_active = 1'b0;
      btn         = 8'hFF;
      mole_up     = 8'h00;
      #1;

      // 1. Reset held with all buttons pressed, then released mid-press.
      applyStimulus(3);
      checkEvents("rst", 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("rst_lock", 32'(locked_out), 32'd0);
      checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
      reset       = 1'b1;
      game_active = 1'b1;
      mole_up     = 8'hFF;
      eventCount  = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1);
         eventCount += int'(miss) + int'(non_full_clear_hit) + int'(full_clear_hit) + int'(mole_whack != 0);
      end
      checkOutput("held_noevent", 32'(eventCount), 32'd0);
      checkOutput("held_state", 32'(dut.state), 32'(ARMED));
      btn     = 8'h00;
      mole_up = 8'h00;
      applyStimulus(2);

      // 2. Partial-clear hit, then the remaining live mole gives a full clear.
      mole_up = 8'b0000_0110;
      btn     = 8'b0000_0010;
      applyStimulus(1);
      checkEvents("hit1", 1'b0, 1'b1, 1'b0, 8'b0000_0010);
      btn = 8'h00;
      applyStimulus(1);
      checkEvents("hit1_width", 1'b0, 1'b0, 1'b0, 8'h00);
      btn = 8'b0000_0100;
      applyStimulus(1);
      checkEvents("hit2", 1'b0, 1'b0, 1'b1, 8'b0000_0100);
      btn = 8'h00;
      applyStimulus(1);
      mole_up = 8'h00;
      applyStimulus(1);

      // 3. Wrong press -> miss and a lockout of exactly LOCKOUT_CYCLES.
      mole_up = 8'b0000_0001;
      btn     = 8'b0000_1000;
      applyStimulus(1);
      checkEvents("miss1", 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("miss1_lock", 32'(locked_out), 32'd1);
      btn        = 8'h00;
      lockCount  = int'(locked_out);
      eventCount = 0;
      for (int i = 1; i <= 14; i++) begin
         if (i == 3) btn = 8'b0000_0001;
         if (i == 4) btn = 8'h00;
         applyStimulus(1);
         lockCount  += int'(locked_out);
         eventCount += int'(miss) + int'(non_full_clear_hit) + int'(full_clear_hit) + int'(mole_whack != 0);
      end
      checkOutput("lock_len", 32'(lockCount), 32'(LOCKOUT_CYCLES));
      checkOutput("lock_quiet", 32'(eventCount), 32'd0);
      checkOutput("lock_state", 32'(dut.state), 32'(ARMED));
      btn = 8'b0000_0001;
      applyStimulus(1);
      checkEvents("post_lock", 1'b0, 1'b0, 1'b1, 8'b0000_0001);
      btn = 8'h00;
      applyStimulus(1);
      mole_up = 8'h00;
      applyStimulus(1);

      // 4. Simultaneous valid + wrong press is a miss; two valid is one event.
      mole_up = 8'b0000_0011;
      btn     = 8'b0010_0001;
      applyStimulus(1);
      checkEvents("mixed", 1'b1, 1'b0, 1'b0, 8'h00);
      btn = 8'h00;
      applyStimulus(LOCKOUT_CYCLES + 2);
      checkOutput("mixed_unlock", 32'(locked_out), 32'd0);
      btn = 8'b0000_0011;
      applyStimulus(1);
      checkEvents("double", 1'b0, 1'b0, 1'b1, 8'b0000_0011);
      btn = 8'h00;
      applyStimulus(1);
      mole_up = 8'h00;
      applyStimulus(1);

      // 5. Held button gives one event; re-press of a knocked mole is a miss.
      mole_up  = 8'b0000_0001;
      btn      = 8'b0000_0001;
      hitCount = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1);
         hitCount += int'(non_full_clear_hit) + int'(full_clear_hit) + int'(miss);
      end
      checkOutput("hold_once", 32'(hitCount), 32'd1);
      btn = 8'h00;
      applyStimulus(1);
      btn = 8'b0000_0001;
      applyStimulus(1);
      checkEvents("repress", 1'b1, 1'b0, 1'b0, 8'h00);
      btn     = 8'h00;
      mole_up = 8'h00;

      // 6. Dropping game_active mid-lockout returns to a clean IDLE.
      applyStimulus(2);
      checkOutput("mid_lock", 32'(locked_out), 32'd1);
      game_active = 1'b0;
      applyStimulus(1);
      checkOutput("abort_lock", 32'(locked_out), 32'd0);
      checkOutput("abort_state", 32'(dut.state), 32'(IDLE));
      checkOutput("abort_cnt", 32'(dut.cnt), 32'd0);
      game_active = 1'b1;
      applyStimulus(1);
      checkOutput("rearm_state", 32'(dut.state), 32'(ARMED));
      checkOutput("rearm_cnt", 32'(dut.cnt), 32'd0);
      checkEvents("rearm", 1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1);
      checkEvents("rearm2", 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("rearm_lock", 32'(locked_out), 32'd0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/hit_classifier.md
Name: hit_classifier

Overview:
- Sits directly upstream of the combo counter. Turns debounced mole-button levels and the mole controller's "mole up" mask into single-cycle scoring events: miss, non_full_clear_hit and full_clear_hit.
- Also returns a per-mole whack pulse to the mole controller so a struck mole is knocked down.
- Applies a miss-penalty lockout so that button mashing cannot farm hits.

Parameters:
- N_MOLES, 8, number of mole holes/buttons; 1..18.
- LOCKOUT_CYCLES, 25_000_000, cycles that presses are ignored after a miss (0.5 s at 50 MHz); 0 disables lockout.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- game_active  input  1  high while a round is running; low forces the IDLE state.
- btn  input  N_MOLES  debounced, already-synchronised button levels, 1 = pressed.
- mole_up  input  N_MOLES  moles currently visible, from the mole controller.
- miss  output  1  one-cycle pulse for a wrong press.
- non_full_clear_hit  output  1  one-cycle pulse for a valid hit that leaves at least one mole up.
- full_clear_hit  output  1  one-cycle pulse for a valid hit that leaves no mole up.
- mole_whack  output  N_MOLES  one-cycle pulse per struck mole.
- locked_out  output  1  high while in LOCKOUT (drives an LED).

Behaviour:
- All outputs are registered.
- While reset=0 at a clock edge, the next state is:
  - miss=0, non_full_clear_hit=0, full_clear_hit=0, mole_whack=0, locked_out=0;
  - btn_q=0, knocked=0, lockout counter=0, state=IDLE.
- Edge detect: rise = btn & ~btn_q. btn_q <= btn every cycle, in every state, including IDLE and LOCKOUT. This means a button held across a state change never produces a late edge.
- knocked mask: marks moles already whacked whose mole_up has not yet fallen.
  - Bit set when mole_whack bit issues.
  - Bit cleared on any cycle where the corresponding mole_up bit is 0.
  - live = mole_up & ~knocked.
- States:
  - IDLE: all event outputs 0. Go to ARMED when game_active=1.
  - ARMED: evaluated on each edge where rise != 0:
    - wrong = rise & ~live; hits = rise & live.
    - If wrong != 0: miss pulses, no hit pulse, mole_whack=0, lockout counter loads LOCKOUT_CYCLES-1, go to LOCKOUT. If LOCKOUT_CYCLES=0, stay in ARMED. Miss dominates any simultaneous valid hits.
    - Else (hits != 0): mole_whack <= hits.
      - If (live & ~hits) == 0: full_clear_hit pulses.
      - Otherwise: non_full_clear_hit pulses.
      - Exactly one event per cycle, however many moles are hit simultaneously.
  - LOCKOUT: rises are ignored silently with no outputs. Counter decrements each cycle; on 0 go to ARMED. locked_out=1 for exactly LOCKOUT_CYCLES cycles.
- game_active=0 in any state: next state IDLE, counter cleared, no pulse issued that cycle.
- Latency: a press first sampled high at edge t produces its event pulse in the cycle after edge t (one-cycle latency). Each pulse is exactly one cycle wide.
- Mutual exclusion: at most one of miss / non_full_clear_hit / full_clear_hit is high in any cycle.
- Holding a button produces exactly one event. Re-pressing an already-knocked mole counts as a miss.
- A press on the same edge that mole_up falls is classified against the sampled mole_up value, which is 0, so it is a miss.
- Lockout counter width: $clog2(LOCKOUT_CYCLES+1), minimum 1.

Decomposition:
- Shared package whack_pkg holds:
  - state encoding typedef hc_state_t {IDLE, ARMED, LOCKOUT};
  - CLK_HZ=50_000_000;
  - MAX_MOLES=18.
- One natural sub-module, rise_detect: a parameterised-width btn_q register plus the rise output. It is reused by the start-button logic.
- The classification logic and the FSM stay inline.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with btn=8'hFF → all outputs 0, state IDLE. Release with btn still 8'hFF and game_active=1 → no event is ever emitted until the button is released and pressed again.
2. mole_up=8'b0000_0110, press btn[1] → non_full_clear_hit=1 for 1 cycle, one cycle after the press; mole_whack=8'b0000_0010. Press btn[2] while mole_up is still 8'b0000_0110 → full_clear_hit=1 (mole 1 is knocked, so it does not count as live).
3. mole_up=8'b0000_0001, press btn[3] → miss=1 for 1 cycle, then locked_out=1 for exactly LOCKOUT_CYCLES cycles (use LOCKOUT_CYCLES=10 in the bench). Press btn[0] during lockout → no pulses. Press it again after lockout → full_clear_hit.
4. mole_up=8'b0000_0011, press btn[0] and btn[5] on the same cycle → miss only, mole_whack=0. Then press btn[0] and btn[1] together → single full_clear_hit with mole_whack=8'b0000_0011.
5. Hold btn[0] for 5 cycles with mole_up[0]=1 → exactly one hit pulse. Re-press btn[0] before mole_up[0] falls → miss.
6. Drop game_active mid-LOCKOUT → locked_out=0 next cycle, state IDLE. Reassert game_active → ARMED with the counter cleared, no spurious pulse.
